mag_window_detect: RTL
======================

// Module: mag_window_detect
// PURPOSE
//   Downstream consumer of the complex-modulus stage. Takes the unsigned magnitude
//   stream (modulus/ovalid) and keeps a sliding-window average over 2^LOG2_LEN samples.
//   A hysteresis state machine raises a detect flag when the averaged magnitude
//   crosses the programmable thresholds. Used for carrier/energy detection ahead of
//   the demod control logic.
// PARAMETERS
//   WIDTH     16  magnitude width; also the width of the average output
//   LOG2_LEN  3   log2 of the window length (window = 8 samples by default)
//   HOLD      4   number of valid samples that detect stays high after the average drops
// PORTS
//   clock    in   1         system clock, rising edge
//   reset    in   1         asynchronous, active-high; clears all state
//   idata    in   WIDTH     unsigned magnitude sample (from modulus)
//   ivalid   in   1         idata qualifier (from modulus ovalid)
//   thr_on   in   WIDTH     detect assert threshold; unsigned; compared with >=
//   thr_off  in   WIDTH     detect release threshold; unsigned; compared with <
//   odata    out  WIDTH     windowed average, sum >> LOG2_LEN (truncating)
//   ovalid   out  1         one-cycle strobe qualifying odata, full and detect
//   full     out  1         window holds 2^LOG2_LEN real samples
//   detect   out  1         energy-detect flag
// BEHAVIOUR
//   - Reset (async): window RAM, wptr, fill count, sum and state all cleared.
//     odata=0, ovalid=0, full=0, detect=0.
//   - Window: circular buffer of 2^LOG2_LEN x WIDTH entries, all entries 0 after reset.
//     wptr wraps modulo 2^LOG2_LEN. Accumulator sum is WIDTH+LOG2_LEN bits wide and
//     cannot overflow.
//   - On a clock edge with ivalid=1:
//     sum <= sum + idata - buf[wptr]; buf[wptr] <= idata; wptr <= wptr+1.
//     odata <= next_sum[WIDTH+LOG2_LEN-1:LOG2_LEN]; ovalid <= 1.
//     Latency: 1 cycle, because the result is registered on the sampling edge.
//   - ivalid=0: ovalid <= 0. odata, full, detect and state hold their values.
//     Back-to-back ivalid is supported at the full clock rate.
//   - Fill: a counter saturates at 2^LOG2_LEN. full rises with the ovalid of the
//     2^LOG2_LEN-th sample and stays high until reset. Before full, the average
//     includes zero entries (under-estimate by design).
//   - FSM states: IDLE, ARMED, ACTIVE, HANG. It is evaluated only on ivalid edges,
//     using avg = the new odata value.
//     IDLE  : waits for the sample that makes the window full; that same sample is then
//             evaluated as ARMED (may go straight to ACTIVE).
//     ARMED : avg >= thr_on -> ACTIVE.
//     ACTIVE: avg < thr_off -> HANG, hold counter loaded with HOLD. If HOLD=0 -> ARMED.
//     HANG  : avg >= thr_on -> ACTIVE (the cancel has priority).
//             Otherwise the counter decrements; on reaching 0 -> ARMED.
//   - detect is registered = (next state is ACTIVE or HANG). It updates on the same
//     edge as odata.
//   - Threshold inputs are sampled every valid sample; changing them mid-stream is
//     legal. If thr_off > thr_on there is no hysteresis band; the rules above apply
//     unchanged.
//   - Reset asserted mid-window or mid-HANG: everything returns to the reset state
//     immediately. The next window starts from empty.
// TESTING (WIDTH=16, LOG2_LEN=3, HOLD=2, 10 ns clock)
//   1. Reset held, random idata/ivalid -> odata=0, ovalid=0, full=0, detect=0 throughout.
//   2. 8 back-to-back samples of 80 -> odata 10,20,...,80, each with a 1-cycle ovalid
//      one cycle after its ivalid. full rises with the 8th ovalid.
//   3. After test 2, 8 samples of 0 -> odata 70,60,...,0 (wrap-around replaces the
//      oldest entry). full stays 1.
//   4. thr_on=50, thr_off=30; full window of 0, then sample stream of 100 -> detect
//      rises on the sample where avg first >=50 (4th: avg=50). Then a stream of 0 ->
//      HANG at first avg<30, detect drops 2 valid samples later. One 100 burst during
//      HANG keeps detect high.
//   5. 8 samples of 65535 -> odata=65535, no wrap of sum. Then one 0 -> odata=57343.
//   6. 5 samples of 80, reset pulse for 3 ns, then 8 samples of 80 -> odata restarts
//      at 10. full only after the 8th post-reset sample.

Source files
------------

// File: rtl/mag_window_detect.sv
// Sliding-window magnitude averager with a hysteresis energy detector.
// Averages the last 2^LOG2_LEN valid samples and flags when the average crosses thr_on/thr_off.
module mag_window_detect #(
    parameter int WIDTH    = 16,
    parameter int LOG2_LEN = 3,
    parameter int HOLD     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] idata,
    input  logic             ivalid,
    input  logic [WIDTH-1:0] thr_on,
    input  logic [WIDTH-1:0] thr_off,
    output logic [WIDTH-1:0] odata,
    output logic             ovalid,
    output logic             full,
    output logic             detect
);

    localparam int LEN    = 1 << LOG2_LEN;
    localparam int SUM_W  = WIDTH + LOG2_LEN;
    localparam int FILL_W = LOG2_LEN + 1;
    localparam int HOLD_W = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        HANG   = 2'd3
    } state_t;

    logic [WIDTH-1:0]  win_r [LEN];
    logic [LOG2_LEN-1:0] wptr_r;
    logic [FILL_W-1:0] fill_r;
    logic [SUM_W-1:0]  sum_r;
    logic [WIDTH-1:0]  odata_r;
    logic              ovalid_r;
    logic              full_r;
    logic              detect_r;
    state_t            state_r;
    logic [HOLD_W-1:0] hold_r;

    logic [SUM_W-1:0]  next_sum_s;
    logic [WIDTH-1:0]  avg_s;
    logic              fill_last_s;
    state_t            state_next_s;
    logic [HOLD_W-1:0] hold_next_s;
    logic [HOLD_W-1:0] hold_dec_s;

    // Running sum: add the newcomer, drop the oldest entry it overwrites.
    always_comb begin
        next_sum_s  = sum_r + {{LOG2_LEN{1'b0}}, idata} - {{LOG2_LEN{1'b0}}, win_r[wptr_r]};
        avg_s       = next_sum_s[SUM_W-1:LOG2_LEN];
        fill_last_s = (fill_r == FILL_W'(LEN - 1));
        hold_dec_s  = hold_r - HOLD_W'(1);
    end

    // Hysteresis next-state; only consulted on valid samples.
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_r;
        case (state_r)
            IDLE: begin
                // The sample that completes the window is judged as if already ARMED.
                if (fill_last_s) begin
                    if (avg_s >= thr_on) begin
                        state_next_s = ACTIVE;
                    end else begin
                        state_next_s = ARMED;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARMED: begin
                if (avg_s >= thr_on) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = ARMED;
                end
            end
            ACTIVE: begin
                if (avg_s < thr_off) begin
                    if (HOLD == 0) begin
                        state_next_s = ARMED;
                    end else begin
                        state_next_s = HANG;
                        hold_next_s  = HOLD_W'(HOLD);
                    end
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            HANG: begin
                if (avg_s >= thr_on) begin
                    state_next_s = ACTIVE;
                end else if (hold_dec_s == {HOLD_W{1'b0}}) begin
                    state_next_s = ARMED;
                    hold_next_s  = {HOLD_W{1'b0}};
                end else begin
                    state_next_s = HANG;
                    hold_next_s  = hold_dec_s;
                end
            end
            default: begin
                state_next_s = IDLE;
                hold_next_s  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Window storage, accumulator, fill tracking and registered average.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LEN; i++) begin
                win_r[i] <= {WIDTH{1'b0}};
            end
            wptr_r   <= {LOG2_LEN{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
            sum_r    <= {SUM_W{1'b0}};
            odata_r  <= {WIDTH{1'b0}};
            ovalid_r <= 1'b0;
            full_r   <= 1'b0;
        end else if (ivalid) begin
            win_r[wptr_r] <= idata;
            wptr_r        <= wptr_r + LOG2_LEN'(1);
            sum_r         <= next_sum_s;
            odata_r       <= avg_s;
            ovalid_r      <= 1'b1;
            full_r        <= full_r | fill_last_s;
            if (fill_r != FILL_W'(LEN)) begin
                fill_r <= fill_r + FILL_W'(1);
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            ovalid_r <= 1'b0;
        end
    end

    // Detector state, hang counter and registered detect flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            hold_r   <= {HOLD_W{1'b0}};
            detect_r <= 1'b0;
        end else if (ivalid) begin
            state_r  <= state_next_s;
            hold_r   <= hold_next_s;
            detect_r <= (state_next_s == ACTIVE) || (state_next_s == HANG);
        end else begin
            state_r  <= state_r;
            hold_r   <= hold_r;
            detect_r <= detect_r;
        end
    end

    assign odata  = odata_r;
    assign ovalid = ovalid_r;
    assign full   = full_r;
    assign detect = detect_r;

endmodule
